// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 telephone keypad scanner and debouncer.
//
// Drives one active-low row per cycle, samples the active-low columns on the
// following edge and folds each 4-row frame into NONE / KEY(k) / MULTI. A key
// is accepted (or released) only after DEBOUNCE_SCANS consecutive frames
// agree. All FSM and output updates happen on the row-3 sample edge.
//
// Ports:
//   clk        system clock (1 kHz)
//   rst        synchronous, active-high reset
//   key_col    column sense lines, active-low
//   key_row    row drive lines, active-low, exactly one low
//   key_out    one-hot digit 0..9 while accepted as held, else zero
//   key_star   high while '*' is accepted as held
//   key_hash   high while '#' is accepted as held
//   key_pulse  one-cycle strobe when a new key is accepted
module keypad_scan #(
    parameter int unsigned DEBOUNCE_SCANS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_col,
    output logic [3:0] key_row,
    output logic [9:0] key_out,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_pulse
);

    localparam logic [3:0] DebScans = 4'(DEBOUNCE_SCANS);
    // Key codes 0..9 are digits; '*' and '#' use the two codes above them.
    localparam logic [3:0] CodeStar = 4'd10;
    localparam logic [3:0] CodeHash = 4'd11;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } state_e;

    logic [1:0] row_idx_q, row_idx_d;
    logic [1:0] acc_cnt_q, acc_cnt_d;
    logic [3:0] acc_code_q, acc_code_d;
    state_e     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;

    // Per-row sample decode
    logic [2:0] col_low;
    logic [1:0] smp_cnt;
    logic [1:0] smp_col;
    logic [3:0] smp_code;

    // Frame-so-far including the current sample
    logic [2:0] sum_cnt;
    logic [1:0] tot_cnt;
    logic [3:0] tot_code;
    logic       frame_end;
    logic       frame_key;
    logic       frame_match;
    logic       held;

    always_comb begin
        col_low = ~key_col;
        smp_cnt = {1'b0, col_low[0]} + {1'b0, col_low[1]} + {1'b0, col_low[2]};
        // Last low column in left-to-right order; only meaningful when exactly one.
        if (col_low[2]) begin
            smp_col = 2'd2;
        end else if (col_low[1]) begin
            smp_col = 2'd1;
        end else begin
            smp_col = 2'd0;
        end
        if (row_idx_q == 2'd3) begin
            unique case (smp_col)
                2'd0:    smp_code = CodeStar;
                2'd1:    smp_code = 4'd0;
                default: smp_code = CodeHash;
            endcase
        end else begin
            smp_code = 4'(row_idx_q) * 4'd3 + 4'(smp_col) + 4'd1;
        end
    end

    always_comb begin
        sum_cnt     = 3'(acc_cnt_q) + 3'(smp_cnt);
        tot_cnt     = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        tot_code    = (smp_cnt != 2'd0) ? smp_code : acc_code_q;
        frame_end   = (row_idx_q == 2'd3);
        frame_key   = (tot_cnt == 2'd1);
        frame_match = frame_key && (tot_code == cand_q);
    end

    // Row counter and frame accumulator
    always_comb begin
        row_idx_d = row_idx_q + 2'd1;
        if (frame_end) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = 4'd0;
        end else begin
            acc_cnt_d  = tot_cnt;
            acc_code_d = tot_code;
        end
    end

    // Debounce FSM, advanced once per frame
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (frame_end) begin
            case (state_q)
                StIdle: begin
                    if (frame_key) begin
                        cand_d  = tot_code;
                        cnt_d   = 4'd1;
                        state_d = StPressWait;
                    end
                end
                StPressWait: begin
                    if (frame_match) begin
                        if (cnt_q + 4'd1 == DebScans) begin
                            cnt_d   = 4'd0;
                            pulse_d = 1'b1;
                            state_d = StHeld;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    // Any other frame, including a second key, starts a release.
                    if (!frame_match) begin
                        cnt_d   = 4'd1;
                        state_d = StReleaseWait;
                    end
                end
                StReleaseWait: begin
                    if (frame_match) begin
                        cnt_d   = 4'd0;
                        state_d = StHeld;
                    end else if (cnt_q + 4'd1 == DebScans) begin
                        cnt_d   = 4'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx_q  <= 2'd0;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
            state_q    <= StIdle;
            cand_q     <= 4'd0;
            cnt_q      <= 4'd0;
            pulse_q    <= 1'b0;
        end else begin
            row_idx_q  <= row_idx_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    // Outputs decode straight from registers so they can only be mutually exclusive.
    always_comb begin
        held      = (state_q == StHeld) || (state_q == StReleaseWait);
        key_row   = ~(4'b0001 << row_idx_q);
        key_out   = 10'd0;
        key_star  = 1'b0;
        key_hash  = 1'b0;
        key_pulse = pulse_q;
        if (held) begin
            if (cand_q < 4'd10) begin
                key_out = 10'd1 << cand_q;
            end
            key_star = (cand_q == CodeStar);
            key_hash = (cand_q == CodeHash);
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a frame-level scoreboard.
// A behavioural key matrix turns the set of pressed keys into column levels.
module tb_keypad_scan;

    localparam int unsigned Deb = 5;

    // Matrix positions r*3+c
    localparam logic [11:0] K1    = 12'h001;
    localparam logic [11:0] K2    = 12'h002;
    localparam logic [11:0] K5    = 12'h010;
    localparam logic [11:0] K9    = 12'h100;
    localparam logic [11:0] KStar = 12'h200;
    localparam logic [11:0] K0    = 12'h400;
    localparam logic [11:0] KHash = 12'h800;
    localparam logic [11:0] KNone = 12'h000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_col;
    logic [3:0] key_row;
    logic [9:0] key_out;
    logic       key_star;
    logic       key_hash;
    logic       key_pulse;

    logic [11:0] pressed;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct {
        string      tag;
        logic [9:0] out;
        logic       star;
        logic       hash;
        logic       pulse;
    } exp_t;

    exp_t sb_q[$];

    keypad_scan #(
        .DEBOUNCE_SCANS(Deb)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_col  (key_col),
        .key_row  (key_row),
        .key_out  (key_out),
        .key_star (key_star),
        .key_hash (key_hash),
        .key_pulse(key_pulse)
    );

    always #5 clk = ~clk;

    always_comb begin
        key_col = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!key_row[r]) begin
                for (int c = 0; c < 3; c++) begin
                    if (pressed[r*3+c]) key_col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One 4-cycle frame with the given keys; called at posedge+1 of a frame boundary.
    task automatic frame(input string tag, input logic [11:0] keys, input logic [9:0] eo,
                         input logic es, input logic eh, input logic ep);
        exp_t e;
        exp_t g;
        pressed = keys;
        e.tag = tag;
        e.out = eo;
        e.star = es;
        e.hash = eh;
        e.pulse = ep;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check({tag, "/pulse_one_cycle"}, 16'(key_pulse), 16'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "/scoreboard_empty"}, 16'(1), 16'(0));
        end else begin
            g = sb_q.pop_front();
            check({g.tag, "/key_out"}, 16'(key_out), 16'(g.out));
            check({g.tag, "/key_star"}, 16'(key_star), 16'(g.star));
            check({g.tag, "/key_hash"}, 16'(key_hash), 16'(g.hash));
            check({g.tag, "/key_pulse"}, 16'(key_pulse), 16'(g.pulse));
            check({g.tag, "/row_align"}, 16'(key_row), 16'(4'b1110));
        end
    endtask

    task automatic press(input string tag, input logic [11:0] keys, input logic [9:0] eo,
                         input logic es, input logic eh);
        for (int i = 0; i < int'(Deb) - 1; i++) frame(tag, keys, 10'd0, 1'b0, 1'b0, 1'b0);
        frame(tag, keys, eo, es, eh, 1'b1);
    endtask

    task automatic release_key(input string tag, input logic [9:0] eo, input logic es,
                               input logic eh);
        for (int i = 0; i < int'(Deb) - 1; i++) frame(tag, KNone, eo, es, eh, 1'b0);
        frame(tag, KNone, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] row_seq [4];
        row_seq[0] = 4'b1101;
        row_seq[1] = 4'b1011;
        row_seq[2] = 4'b0111;
        row_seq[3] = 4'b1110;

        // Reset
        pressed = KNone;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset/key_row", 16'(key_row), 16'(4'b1110));
        check("reset/outputs", 16'({key_out, key_star, key_hash, key_pulse}), 16'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset/row_seq%0d", i), 16'(key_row), 16'(row_seq[i]));
        end

        // Clean press and release of '5'
        press("press5", K5, 10'b0000100000, 1'b0, 1'b0);
        frame("held5", K5, 10'b0000100000, 1'b0, 1'b0, 1'b0);
        release_key("rel5", 10'b0000100000, 1'b0, 1'b0);

        // Bounce on '0': present, present, absent, then stable
        frame("bounce0_f1", K0, 10'd0, 1'b0, 1'b0, 1'b0);
        frame("bounce0_f2", K0, 10'd0, 1'b0, 1'b0, 1'b0);
        frame("bounce0_f3", KNone, 10'd0, 1'b0, 1'b0, 1'b0);
        press("bounce0_f4to8", K0, 10'b0000000001, 1'b0, 1'b0);
        frame("held0", K0, 10'b0000000001, 1'b0, 1'b0, 1'b0);
        frame("drop0_a", KNone, 10'b0000000001, 1'b0, 1'b0, 1'b0);
        frame("drop0_b", KNone, 10'b0000000001, 1'b0, 1'b0, 1'b0);
        frame("back0_a", K0, 10'b0000000001, 1'b0, 1'b0, 1'b0);
        frame("back0_b", K0, 10'b0000000001, 1'b0, 1'b0, 1'b0);
        release_key("rel0", 10'b0000000001, 1'b0, 1'b0);

        // Two keys together never accept; then '1' alone does
        for (int i = 0; i < 3; i++) frame("multi12", K1 | K2, 10'd0, 1'b0, 1'b0, 1'b0);
        press("press1", K1, 10'b0000000010, 1'b0, 1'b0);
        release_key("rel1", 10'b0000000010, 1'b0, 1'b0);

        // Star and hash
        press("star", KStar, 10'd0, 1'b1, 1'b0);
        release_key("rel_star", 10'd0, 1'b1, 1'b0);
        press("hash", KHash, 10'd0, 1'b0, 1'b1);
        release_key("rel_hash", 10'd0, 1'b0, 1'b1);

        // Reset while '9' is held
        press("press9", K9, 10'b1000000000, 1'b0, 1'b0);
        frame("held9", K9, 10'b1000000000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_held/outputs", 16'({key_out, key_star, key_hash, key_pulse}), 16'(0));
        check("rst_held/key_row", 16'(key_row), 16'(4'b1110));
        rst = 1'b0;
        press("repress9", K9, 10'b1000000000, 1'b0, 1'b0);
        release_key("rel9", 10'b1000000000, 1'b0, 1'b0);

        check("scoreboard_drained", 16'(sb_q.size()), 16'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
